divisor_seq: RTL and testbench
==============================

DIVISOR_SEQ -- requirements
Module: divisor_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result bit width (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a division; sampled on clk.
REQ-005 The block SHALL have port sgn, input, 1, signed-mode select; sampled with start.
REQ-006 The block SHALL have port A, input, WIDTH, dividend; sampled with start.
REQ-007 The block SHALL have port B, input, WIDTH, divisor; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, division in progress.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking results valid.
REQ-010 The block SHALL have port Q, output, WIDTH, quotient.
REQ-011 The block SHALL have port R, output, WIDTH, remainder.
REQ-012 The block SHALL have port R_exists, output, 1, high when R != 0 and ERRO = 0.
REQ-013 The block SHALL have port ERRO, output, 1, divide-by-zero flag.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 start SHALL be accepted only in IDLE or DONE; on acceptance, A, B and sgn SHALL be latched internally.
REQ-016 start asserted while in RUN SHALL be ignored, with no effect on state, outputs or latched operands.
REQ-017 On accepted start with B != 0, the FSM SHALL enter RUN and perform one restoring iteration per clock, WIDTH iterations in total.
  - Each iteration: shift partial remainder left, bring in the next dividend bit from MSB first, trial-subtract B.
  - If no borrow: keep the difference and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
REQ-018 The partial remainder SHALL be WIDTH+1 bits wide so the trial subtraction never overflows.
REQ-019 busy SHALL be high in every cycle the FSM is in RUN, and low otherwise.
REQ-020 done SHALL be high for exactly one cycle, WIDTH+1 clock edges after the accepting edge; the FSM SHALL then be in DONE.
REQ-021 Q, R, R_exists and ERRO SHALL update only on the edge that raises done, and SHALL hold until the next done.
REQ-022 Divide by zero (B == 0): the FSM SHALL skip RUN, and done SHALL pulse on the next edge.
  - Outputs: ERRO = 1, Q = 0, R = A, R_exists = 0.
REQ-023 Any accepted start with B != 0 SHALL produce ERRO = 0.
REQ-024 The FSM SHALL leave DONE for IDLE after one cycle unless start is high in that cycle, in which case it SHALL accept the new operation back-to-back.
REQ-025 Unsigned results SHALL satisfy A = Q*B + R with R < B.

Reset
REQ-026 While rst_n = 0, the FSM SHALL be in IDLE, and busy, done, Q, R, R_exists and ERRO SHALL all be 0, independent of clk.
REQ-027 Reset asserted during RUN SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.
REQ-028 Internal operand and partial-remainder registers SHALL be cleared by reset.

Configuration
REQ-029 The macro DIVISOR_SEQ_SIGNED_EN SHALL control signed-mode support.
REQ-030 With DIVISOR_SEQ_SIGNED_EN defined and sgn = 1, operands SHALL be treated as two's complement, with the following rules:
  - Magnitudes are divided.
  - Q is truncated toward zero.
  - R takes the sign of A.
  - Latency is unchanged (WIDTH+1).
REQ-031 With DIVISOR_SEQ_SIGNED_EN defined, most-negative / -1 SHALL return Q = most-negative value, R = 0, ERRO = 0.
REQ-032 Without DIVISOR_SEQ_SIGNED_EN, sgn SHALL be ignored, all operations SHALL be unsigned, and no sign-correction logic SHALL be synthesised.

Verification
REQ-033 WIDTH=8, A=200, B=7, start one cycle -> busy for 8 cycles; done 9 edges after start; Q=28, R=4, R_exists=1, ERRO=0.
REQ-034 WIDTH=8, A=5, B=0 -> done on next edge; ERRO=1, Q=0, R=5, R_exists=0.
REQ-035 WIDTH=8, A=255, B=255; start re-asserted at cycle 3 -> re-assertion ignored; single done; Q=1, R=0, R_exists=0.
REQ-036 WIDTH=8, A=100, B=3; rst_n pulled low at cycle 4 -> all outputs 0 immediately, no done; next start with A=9, B=3 -> Q=3, R=0.
REQ-037 WIDTH=8, DIVISOR_SEQ_SIGNED_EN defined, sgn=1, A=0xF9 (-7), B=2 -> Q=0xFD (-3), R=0xFF (-1); and A=0x80, B=0xFF -> Q=0x80, R=0.
REQ-038 WIDTH=16, A=65535, B=3, then back-to-back start in DONE with A=1000, B=10 -> Q=21845, R=0; then Q=100, R=0, with no idle cycle between operations.

Source files
------------

// File: rtl/divisor_seq.sv
// Sequential restoring divider: one quotient bit per clock, results and done one edge after the last bit.
// Optional two's-complement mode is compiled in with `define DIVISOR_SEQ_SIGNED_EN.
module divisor_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             R_exists,
  output logic             ERRO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH:0]   rem_p0;
  logic [WIDTH-1:0] qa_p0;
  logic [WIDTH-1:0] b_p0;
  logic             dz_p0;
  logic             vld_p0;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             accept;
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;

`ifdef DIVISOR_SEQ_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q_p0;
  logic neg_r_p0;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign a_neg = sgn & A[WIDTH-1];
  assign b_neg = sgn & B[WIDTH-1];
  assign a_mag = cond_neg(A, a_neg);
  assign b_mag = cond_neg(B, b_neg);
  assign q_fin = cond_neg(qa_p0, neg_q_p0);
  assign r_fin = cond_neg(rem_p0[WIDTH-1:0], neg_r_p0);

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_p0 <= 1'b0;
      neg_r_p0 <= 1'b0;
    end else if (accept) begin
      neg_q_p0 <= a_neg ^ b_neg;
      neg_r_p0 <= a_neg;
    end
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_mag      = A;
  assign b_mag      = B;
  assign q_fin      = qa_p0;
  assign r_fin      = rem_p0[WIDTH-1:0];
`endif

  assign accept = start & (((state == IDLE) & ~vld_p0) | (state == DONE));
  assign busy   = (state == RUN);

  // Trial subtraction one bit wider than the remainder so the borrow is explicit.
  assign trial   = {rem_p0, qa_p0[WIDTH-1]};
  assign diff    = trial - {2'b00, b_p0};
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_nxt = q_bit ? diff[WIDTH:0] : trial[WIDTH:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_p0   <= '0;
      rem_p0   <= '0;
      qa_p0    <= '0;
      b_p0     <= '0;
      dz_p0    <= 1'b0;
      vld_p0   <= 1'b0;
      done     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      R_exists <= 1'b0;
      ERRO     <= 1'b0;
    end else begin
      done <= 1'b0;
      // Stage p0: operand capture, or one restoring step per clock
      if (accept) begin
        b_p0   <= b_mag;
        cnt_p0 <= '0;
        if (b_mag == '0) begin
          rem_p0 <= {1'b0, a_mag};
          qa_p0  <= '0;
          dz_p0  <= 1'b1;
          vld_p0 <= 1'b1;
          state  <= IDLE;
        end else begin
          rem_p0 <= '0;
          qa_p0  <= a_mag;
          dz_p0  <= 1'b0;
          state  <= RUN;
        end
      end else if (state == RUN) begin
        rem_p0 <= rem_nxt;
        qa_p0  <= {qa_p0[WIDTH-2:0], q_bit};
        cnt_p0 <= cnt_p0 + CNT_W'(1);
        if (cnt_p0 == LAST) begin
          state  <= IDLE;
          vld_p0 <= 1'b1;
        end
      // Stage p1: sign fix-up and result registers
      end else if (vld_p0) begin
        Q        <= q_fin;
        R        <= r_fin;
        R_exists <= ~dz_p0 & (r_fin != '0);
        ERRO     <= dz_p0;
        done     <= 1'b1;
        vld_p0   <= 1'b0;
        state    <= DONE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_divisor_seq.sv
// Bench for divisor_seq: an arithmetic/timing model checked every cycle plus directed literal cases,
// on a WIDTH=8 and a WIDTH=16 instance.
module tb_divisor_seq;

`ifdef DIVISOR_SEQ_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        st[2];
  logic        sg[2];
  logic [31:0] av[2];
  logic [31:0] bv[2];

  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;
  logic        bz8, dn8, rx8, er8, bz16, dn16, rx16, er16;

  logic [31:0] qd[2], rd[2];
  logic        dd[2], bd[2], xd[2], ed[2];

  int n_cmp = 0;
  int n_bad = 0;

  divisor_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sgn(sg[0]), .A(av[0][7:0]), .B(bv[0][7:0]),
    .busy(bz8), .done(dn8), .Q(q8), .R(r8), .R_exists(rx8), .ERRO(er8)
  );

  divisor_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sgn(sg[1]), .A(av[1][15:0]), .B(bv[1][15:0]),
    .busy(bz16), .done(dn16), .Q(q16), .R(r16), .R_exists(rx16), .ERRO(er16)
  );

  assign qd[0] = {24'b0, q8};
  assign rd[0] = {24'b0, r8};
  assign qd[1] = {16'b0, q16};
  assign rd[1] = {16'b0, r16};
  assign dd[0] = dn8;
  assign dd[1] = dn16;
  assign bd[0] = bz8;
  assign bd[1] = bz16;
  assign xd[0] = rx8;
  assign xd[1] = rx16;
  assign ed[0] = er8;
  assign ed[1] = er16;

  function automatic int wof(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  // sel: 0 quotient, 1 remainder, 2 R_exists, 3 ERRO
  function automatic logic [31:0] mdiv(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic s, input int sel);
    logic [31:0] mask, q, r;
    longint sa, sb;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (b == 32'd0) begin
      q = 32'd0;
      r = a;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      if (SEN && s) begin
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
      end
      q = 32'(sa / sb) & mask;
      r = 32'(sa % sb) & mask;
    end
    case (sel)
      0:       return q;
      1:       return r;
      2:       return {31'b0, (b != 32'd0) && (r != 32'd0)};
      default: return {31'b0, b == 32'd0};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: accepted starts become a result due at a known edge, held until the next one.
  longint      ecyc = 0;
  longint      m_de[2]  = '{-1, -1};
  longint      m_blo[2] = '{1, 1};
  longint      m_bhi[2] = '{0, 0};
  logic [31:0] p_q[2], p_r[2], p_x[2], p_e[2];
  logic [31:0] h_q[2] = '{0, 0};
  logic [31:0] h_r[2] = '{0, 0};
  logic [31:0] h_x[2] = '{0, 0};
  logic [31:0] h_e[2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_de[i]  <= -1;
        m_blo[i] <= 1;
        m_bhi[i] <= 0;
        h_q[i]   <= 32'd0;
        h_r[i]   <= 32'd0;
        h_x[i]   <= 32'd0;
        h_e[i]   <= 32'd0;
      end
    end else begin
      ecyc <= ecyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_de[i] == ecyc + 1) begin
          h_q[i] <= p_q[i];
          h_r[i] <= p_r[i];
          h_x[i] <= p_x[i];
          h_e[i] <= p_e[i];
        end
        if (st[i] && (m_de[i] < ecyc + 1)) begin
          p_q[i] <= mdiv(wof(i), av[i], bv[i], sg[i], 0);
          p_r[i] <= mdiv(wof(i), av[i], bv[i], sg[i], 1);
          p_x[i] <= mdiv(wof(i), av[i], bv[i], sg[i], 2);
          p_e[i] <= mdiv(wof(i), av[i], bv[i], sg[i], 3);
          if (bv[i] == 32'd0) begin
            m_de[i]  <= ecyc + 2;
            m_blo[i] <= 1;
            m_bhi[i] <= 0;
          end else begin
            m_de[i]  <= ecyc + 2 + longint'(wof(i));
            m_blo[i] <= ecyc + 1;
            m_bhi[i] <= ecyc + longint'(wof(i));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cyc_w%0d_done", wof(i)), {31'b0, dd[i]}, {31'b0, m_de[i] == ecyc});
      chk($sformatf("cyc_w%0d_busy", wof(i)), {31'b0, bd[i]},
          {31'b0, (m_blo[i] <= ecyc) && (ecyc <= m_bhi[i])});
      chk($sformatf("cyc_w%0d_Q", wof(i)), qd[i], h_q[i]);
      chk($sformatf("cyc_w%0d_R", wof(i)), rd[i], h_r[i]);
      chk($sformatf("cyc_w%0d_R_exists", wof(i)), {31'b0, xd[i]}, h_x[i]);
      chk($sformatf("cyc_w%0d_ERRO", wof(i)), {31'b0, ed[i]}, h_e[i]);
    end
  end

  // Caller is at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input logic ex, input logic ee,
                        input int elat, input int ebusy, input int poke, input string nm);
    int lat;
    int nbusy;
    bit seen;
    av[i] = a;
    bv[i] = b;
    sg[i] = s;
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    lat   = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && lat <= 40) begin
      if (dd[i]) seen = 1'b1;
      else begin
        if (bd[i]) nbusy++;
        if (lat == poke) begin
          av[i] = 32'd10;
          bv[i] = 32'd2;
          st[i] = 1'b1;
        end
        @(negedge clk);
        st[i] = 1'b0;
        lat++;
      end
    end
    chk({nm, "_latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(elat));
    chk({nm, "_busy_cycles"}, 32'(nbusy), 32'(ebusy));
    chk({nm, "_Q"}, qd[i], eq);
    chk({nm, "_R"}, rd[i], er);
    chk({nm, "_R_exists"}, {31'b0, xd[i]}, {31'b0, ex});
    chk({nm, "_ERRO"}, {31'b0, ed[i]}, {31'b0, ee});
  endtask

  initial begin
    int extra;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      sg[i] = 1'b0;
      av[i] = 32'd0;
      bv[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    chk("reset_Q", qd[0], 32'd0);
    chk("reset_R", rd[0], 32'd0);
    chk("reset_busy_done", {30'b0, bd[0], dd[0]}, 32'd0);
    chk("reset_flags", {30'b0, xd[0], ed[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 32'd200, 32'd7, 1'b0, 32'd28, 32'd4, 1'b1, 1'b0, 9, 8, -1, "u200_7");
    @(negedge clk);
    run_op(0, 32'd5, 32'd0, 1'b0, 32'd0, 32'd5, 1'b0, 1'b1, 1, 0, -1, "div0");
    @(negedge clk);
    run_op(0, 32'd255, 32'd255, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 9, 8, 3, "start_in_run");
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (dd[0]) extra++;
    end
    chk("start_in_run_extra_done", 32'(extra), 32'd0);

    av[0] = 32'd100;
    bv[0] = 32'd3;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", {31'b0, bd[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_Q", qd[0], 32'd0);
    chk("abort_R", rd[0], 32'd0);
    chk("abort_busy_done", {30'b0, bd[0], dd[0]}, 32'd0);
    chk("abort_flags", {30'b0, xd[0], ed[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (dd[0]) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    run_op(0, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 9, 8, -1, "after_abort");
    @(negedge clk);

    run_op(0, 32'd7, 32'd9, 1'b0, 32'd0, 32'd7, 1'b1, 1'b0, 9, 8, -1, "a_lt_b");
    @(negedge clk);
    run_op(0, 32'd255, 32'd1, 1'b0, 32'd255, 32'd0, 1'b0, 1'b0, 9, 8, -1, "div_by_1");
    @(negedge clk);
`ifdef DIVISOR_SEQ_SIGNED_EN
    run_op(0, 32'hF9, 32'd2, 1'b1, 32'hFD, 32'hFF, 1'b1, 1'b0, 9, 8, -1, "s_m7_2");
    @(negedge clk);
    run_op(0, 32'h80, 32'hFF, 1'b1, 32'h80, 32'd0, 1'b0, 1'b0, 9, 8, -1, "s_min_m1");
`else
    run_op(0, 32'hF9, 32'd2, 1'b1, 32'h7C, 32'd1, 1'b1, 1'b0, 9, 8, -1, "sgn_ignored");
`endif
    @(negedge clk);

    run_op(1, 32'd65535, 32'd3, 1'b0, 32'd21845, 32'd0, 1'b0, 1'b0, 17, 16, -1, "w16_first");
    run_op(1, 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0, 17, 16, -1, "w16_b2b");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, required < 100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
